// File: rtl/fclk_generator.sv
// Programmable slow clock-enable generator with free-run / stop / single-step control.
// Optional `FCLK_CYCLE_COUNTER_EN adds a 32-bit count of generated fclk periods.
module fclk_generator #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [CNT_W-1:0] div,
  output logic             fclk,
  output logic             fclk_rise,
  output logic             fclk_fall,
  output logic             busy
`ifdef FCLK_CYCLE_COUNTER_EN
  ,
  output logic [31:0]      fclk_cycles
`endif
);

  localparam logic [CNT_W-1:0] RESET_H = (DEFAULT_DIV == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] h, h_n;
  logic             fclk_n, rise_n, fall_n, busy_n;
  logic [CNT_W-1:0] div_eff;
  logic             half_end;

  assign div_eff  = (div == '0) ? CNT_W'(1) : div;
  // h is never 0, so h-1 cannot underflow and cnt never wraps.
  assign half_end = (cnt == h - CNT_W'(1));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    h_n     = h;
    fclk_n  = fclk;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      IDLE: begin
        fclk_n = 1'b0;
        if (run || step) begin
          state_n = run ? RUN : STEP;
          fclk_n  = 1'b1;
          rise_n  = 1'b1;
          cnt_n   = '0;
          h_n     = div_eff;
        end
      end
      RUN, STEP: begin
        if (half_end) begin
          cnt_n = '0;
          if (fclk) begin
            fclk_n = 1'b0;
            fall_n = 1'b1;
          end else if (state == RUN && run) begin
            // Period boundary in free-run: rise again and pick up the new divisor.
            fclk_n = 1'b1;
            rise_n = 1'b1;
            h_n    = div_eff;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        fclk_n  = 1'b0;
        cnt_n   = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      h         <= RESET_H;
      fclk      <= 1'b0;
      fclk_rise <= 1'b0;
      fclk_fall <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      h         <= h_n;
      fclk      <= fclk_n;
      fclk_rise <= rise_n;
      fclk_fall <= fall_n;
      busy      <= busy_n;
    end
  end

`ifdef FCLK_CYCLE_COUNTER_EN
  // Counts on the same edge that raises fclk_rise, so it stays aligned with the strobe.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      fclk_cycles <= 32'd0;
    end else if (rise_n) begin
      fclk_cycles <= fclk_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fclk_generator.sv
// Self-checking bench for fclk_generator: directed vector table, hand sequences and
// random stimulus compared against a period-queue reference model.
module tb_fclk_generator;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             run;
  logic             step;
  logic [CNT_W-1:0] div;
  logic             fclk, fclk_rise, fclk_fall, busy;
`ifdef FCLK_CYCLE_COUNTER_EN
  logic [31:0]      fclk_cycles;
`endif

  fclk_generator #(.CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
    .CLK        (clk),
    .rst        (rst),
    .run        (run),
    .step       (step),
    .div        (div),
    .fclk       (fclk),
    .fclk_rise  (fclk_rise),
    .fclk_fall  (fclk_fall),
    .busy       (busy)
`ifdef FCLK_CYCLE_COUNTER_EN
    ,
    .fclk_cycles(fclk_cycles)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A started period is expanded into its full list of future fclk levels;
  // the model only decides what happens when that list runs out.
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2;
  bit          m_q[$];
  int          m_mode;
  bit          m_fclk, m_prev;
  int unsigned m_rises;

  function automatic void model_reset();
    m_q.delete();
    m_mode  = M_IDLE;
    m_fclk  = 1'b0;
    m_prev  = 1'b0;
    m_rises = 0;
  endfunction

  function automatic void model_start(input int unsigned d, input int mode);
    int unsigned hh;
    hh = (d == 0) ? 1 : d;
    m_fclk = 1'b1;
    for (int i = 0; i < int'(hh) - 1; i++) m_q.push_back(1'b1);
    for (int i = 0; i < int'(hh); i++) m_q.push_back(1'b0);
    m_mode  = mode;
    m_rises = m_rises + 1;
  endfunction

  function automatic void model_edge(input bit r, input bit s, input int unsigned d);
    m_prev = m_fclk;
    if (m_q.size() > 0) m_fclk = m_q.pop_front();
    else if (m_mode == M_RUN && r) model_start(d, M_RUN);
    else if (m_mode != M_IDLE) begin
      m_mode = M_IDLE;
      m_fclk = 1'b0;
    end
    else if (r) model_start(d, M_RUN);
    else if (s) model_start(d, M_STEP);
    else m_fclk = 1'b0;
  endfunction

  // ---------------- driver ----------------
  bit log_fclk[$];
  int dut_rises;

  task automatic compare_model();
    check("fclk", 32'(fclk), 32'(m_fclk));
    check("fclk_rise", 32'(fclk_rise), 32'(m_fclk & ~m_prev));
    check("fclk_fall", 32'(fclk_fall), 32'(~m_fclk & m_prev));
    check("busy", 32'(busy), 32'(m_mode != M_IDLE));
`ifdef FCLK_CYCLE_COUNTER_EN
    check("fclk_cycles", fclk_cycles, m_rises);
`endif
  endtask

  // Called at a negedge: apply inputs, let one posedge pass, sample at the next negedge.
  task automatic cycle(input bit r, input bit s, input logic [CNT_W-1:0] d);
    run  = r;
    step = s;
    div  = d;
    model_edge(r, s, int'(d));
    @(posedge clk);
    @(negedge clk);
    log_fclk.push_back(fclk);
    if (fclk_rise) dut_rises++;
    compare_model();
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    run  = 1'b0;
    step = 1'b0;
    #1;
    check("rst_fclk", 32'(fclk), 32'd0);
    check("rst_rise", 32'(fclk_rise), 32'd0);
    check("rst_fall", 32'(fclk_fall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef FCLK_CYCLE_COUNTER_EN
    check("rst_cycles", fclk_cycles, 32'd0);
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    log_fclk.delete();
    dut_rises = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit               r;
    bit               s;
    logic [CNT_W-1:0] d;
    bit               f;
    bit               ri;
    bit               fa;
    bit               b;
  } vec_t;

  vec_t vecs[14];
  int   hl[$];
  int   run_len;

  initial begin
    rst  = 1'b1;
    run  = 1'b0;
    step = 1'b0;
    div  = '0;
    dut_rises = 0;
    model_reset();

    // step with div=0 (H=1), a second step during STEP, run during STEP ignored,
    // then run+step together entering RUN with div=2, then run dropped.
    vecs[0]  = '{1'b0, 1'b1, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 16'd2, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 16'd2, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 16'd2, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      run  = vecs[i].r;
      step = vecs[i].s;
      div  = vecs[i].d;
      model_edge(vecs[i].r, vecs[i].s, int'(vecs[i].d));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_fclk", i), 32'(fclk), 32'(vecs[i].f));
      check($sformatf("vec%0d_rise", i), 32'(fclk_rise), 32'(vecs[i].ri));
      check($sformatf("vec%0d_fall", i), 32'(fclk_fall), 32'(vecs[i].fa));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].b));
    end

    // div=3 with run held: 3 high / 3 low, repeating.
    do_reset();
    for (int i = 0; i < 18; i++) cycle(1'b1, 1'b0, 16'd3);
    check("div3_rises", 32'(dut_rises), 32'd3);
    for (int i = 0; i < 6; i++)
      check($sformatf("div3_shape%0d", i), 32'(log_fclk[i]), 32'(i < 3));

    // div 2 -> 5 mid-high: current period stays 2+2, next is 5+5.
    do_reset();
    cycle(1'b1, 1'b0, 16'd2);
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 16'd5);
    hl.delete();
    run_len = 0;
    foreach (log_fclk[i]) begin
      if (log_fclk[i]) run_len++;
      else if (run_len != 0) begin
        hl.push_back(run_len);
        run_len = 0;
      end
    end
    check("divchg_nhalves", 32'(hl.size() >= 2), 32'd1);
    if (hl.size() >= 2) begin
      check("divchg_first_high", 32'(hl[0]), 32'd2);
      check("divchg_second_high", 32'(hl[1]), 32'd5);
    end
    check("divchg_low_len", 32'(log_fclk[2] == 0 && log_fclk[3] == 0 && log_fclk[4] == 1), 32'd1);

    // div=4, drop run one cycle after the rise: full period then IDLE.
    do_reset();
    cycle(1'b1, 1'b0, 16'd4);
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 16'd4);
    run_len = 0;
    foreach (log_fclk[i]) run_len += int'(log_fclk[i]);
    check("stop_high_cycles", 32'(run_len), 32'd4);
    check("stop_rises", 32'(dut_rises), 32'd1);
    check("stop_fclk", 32'(fclk), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);

    // Back-to-back steps with div=3: rises spaced 2H+1 = 7 cycles.
    do_reset();
    cycle(1'b0, 1'b1, 16'd3);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 16'd3);
    cycle(1'b0, 1'b1, 16'd3);
    check("b2b_second_rise", 32'(fclk_rise), 32'd1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 16'd3);
    check("b2b_rises", 32'(dut_rises), 32'd2);

    // Three RUN periods then async reset mid-high with div=6.
    do_reset();
    for (int i = 0; i < 36; i++) cycle(1'b1, 1'b0, 16'd6);
    cycle(1'b1, 1'b0, 16'd6);
    cycle(1'b1, 1'b0, 16'd6);
`ifdef FCLK_CYCLE_COUNTER_EN
    check("cycles_after_periods", fclk_cycles, 32'd4);
`endif
    check("pre_reset_high", 32'(fclk), 32'd1);
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 16'd6);
    check("post_reset_rises", 32'(dut_rises), 32'd0);

    // Random stimulus against the model.
    do_reset();
    begin
      bit               r_rnd;
      logic [CNT_W-1:0] d_rnd;
      r_rnd = 1'b0;
      d_rnd = 16'd1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 39) == 0) r_rnd = ~r_rnd;
        if ($urandom_range(0, 19) == 0) d_rnd = 16'($urandom_range(0, 5));
        cycle(r_rnd, $urandom_range(0, 7) == 0, d_rnd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
